// File: rtl/lfsr_checker_if.sv
// Sample/status bundle between an LFSR source and lfsr_checker.
// The source drives in_valid/in_q/clear; the checker drives the status outputs.
interface lfsr_checker_if #(
  parameter int N = 8
);
  logic         in_valid;
  logic [1:N]   in_q;
  logic         clear;
  logic         locked;
  logic         err_pulse;
  logic [15:0]  err_cnt;
  logic         stuck_zero;
  logic [15:0]  period;
  logic         period_valid;

  modport master (
    output in_valid, in_q, clear,
    input  locked, err_pulse, err_cnt, stuck_zero, period, period_valid
  );

  modport slave (
    input  in_valid, in_q, clear,
    output locked, err_pulse, err_cnt, stuck_zero, period, period_valid
  );
endinterface

// File: rtl/lfsr_checker.sv
// LFSR stream checker: locks onto an incoming LFSR state stream, counts errors,
// flags all-zero samples. Define LFSR_CHK_PERIOD_EN to build period measurement.
module lfsr_checker #(
  parameter int         N          = 8,
  parameter logic [1:N] TAPS       = 8'b00011101,
  parameter int         LOCK_CNT   = 4,
  parameter int         UNLOCK_CNT = 3
) (
  input  logic          clk,
  input  logic          reset,
  lfsr_checker_if.slave chk
);

  typedef enum logic [1:0] {HUNT, CONFIRM, LOCKED} state_t;

  state_t      state_reg, state_next;
  logic [1:N]  pred_reg, pred_next;
  logic [3:0]  match_reg, match_next;
  logic [3:0]  miss_reg, miss_next;
  logic        locked_reg;
  logic        err_pulse_reg;
  logic [15:0] err_cnt_reg, err_cnt_next;
  logic        stuck_reg, stuck_next;
  logic        err_now;
  logic        zero_in;
  logic        in_match;
  logic [1:N]  f_in, f_pred;

  // Next-state function applied both to the raw sample (seeding) and to the flywheel
  assign f_in[1]   = ^(chk.in_q & TAPS);
  assign f_pred[1] = ^(pred_reg & TAPS);

  genvar gi;
  generate
    for (gi = 2; gi <= N; gi++) begin : g_shift
      assign f_in[gi]   = chk.in_q[gi-1];
      assign f_pred[gi] = pred_reg[gi-1];
    end
  endgenerate

  assign zero_in  = (chk.in_q == '0);
  assign in_match = (chk.in_q == pred_reg);

  always_comb begin
    state_next = state_reg;
    pred_next  = pred_reg;
    match_next = match_reg;
    miss_next  = miss_reg;
    err_now    = 1'b0;
    if (chk.in_valid) begin
      case (state_reg)
        HUNT: begin
          if (!zero_in) begin
            pred_next  = f_in;
            match_next = '0;
            state_next = CONFIRM;
          end
        end
        CONFIRM: begin
          if (in_match) begin
            match_next = match_reg + 4'd1;
            pred_next  = f_pred;
            if (match_next == 4'(LOCK_CNT)) begin
              state_next = LOCKED;
              miss_next  = '0;
            end
          end else begin
            pred_next  = f_in;
            match_next = '0;
          end
        end
        LOCKED: begin
          pred_next = f_pred;
          if (in_match) begin
            miss_next = '0;
          end else begin
            err_now   = 1'b1;
            miss_next = miss_reg + 4'd1;
            if (miss_next == 4'(UNLOCK_CNT)) begin
              state_next = HUNT;
              miss_next  = '0;
            end
          end
        end
        default: state_next = HUNT;
      endcase
    end
  end

  // A counted error in the same cycle as clear leaves the count at 1
  always_comb begin
    err_cnt_next = err_cnt_reg;
    if (chk.clear)
      err_cnt_next = err_now ? 16'd1 : 16'd0;
    else if (err_now && err_cnt_reg != 16'hFFFF)
      err_cnt_next = err_cnt_reg + 16'd1;
    stuck_next = (chk.clear ? 1'b0 : stuck_reg) | (chk.in_valid & zero_in);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= HUNT;
      pred_reg      <= '0;
      match_reg     <= '0;
      miss_reg      <= '0;
      locked_reg    <= 1'b0;
      err_pulse_reg <= 1'b0;
      err_cnt_reg   <= '0;
      stuck_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      pred_reg      <= pred_next;
      match_reg     <= match_next;
      miss_reg      <= miss_next;
      locked_reg    <= (state_next == LOCKED);
      err_pulse_reg <= err_now;
      err_cnt_reg   <= err_cnt_next;
      stuck_reg     <= stuck_next;
    end
  end

  assign chk.locked     = locked_reg;
  assign chk.err_pulse  = err_pulse_reg;
  assign chk.err_cnt    = err_cnt_reg;
  assign chk.stuck_zero = stuck_reg;

`ifdef LFSR_CHK_PERIOD_EN
  logic [1:N]  anchor_reg;
  logic [15:0] pcnt_reg;
  logic [15:0] period_reg;
  logic        period_valid_reg;

  // Anchor is the first state expected after lock, so a full cycle counts exactly the period
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      anchor_reg       <= '0;
      pcnt_reg         <= '0;
      period_reg       <= '0;
      period_valid_reg <= 1'b0;
    end else begin
      period_valid_reg <= 1'b0;
      if (state_reg != LOCKED && state_next == LOCKED) begin
        anchor_reg <= pred_next;
        pcnt_reg   <= '0;
      end else if (state_reg == LOCKED && chk.in_valid) begin
        if (chk.in_q == anchor_reg && pcnt_reg != 16'd0 && pcnt_reg != 16'hFFFF) begin
          period_reg       <= pcnt_reg;
          period_valid_reg <= 1'b1;
          pcnt_reg         <= 16'd1;
        end else if (pcnt_reg != 16'hFFFF) begin
          pcnt_reg <= pcnt_reg + 16'd1;
        end
      end
    end
  end

  assign chk.period       = period_reg;
  assign chk.period_valid = period_valid_reg;
`else
  assign chk.period       = 16'd0;
  assign chk.period_valid = 1'b0;
`endif

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed self-checking bench for lfsr_checker (N=8, taps 4,5,6,8, seed 1).
module tb_lfsr_checker;
  localparam int N = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  lfsr_checker_if #(.N(N)) bus ();

  lfsr_checker #(
    .N(N), .TAPS(8'b00011101), .LOCK_CNT(4), .UNLOCK_CNT(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .chk(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [1:N] gen;
  logic [1:N] flip3;

  function automatic logic [1:N] lfsr_step(input logic [1:N] s);
    return {s[4] ^ s[5] ^ s[6] ^ s[8], s[1:7]};
  endfunction

  task automatic send(input logic v, input logic [1:N] q, input logic clr);
    bus.in_valid = v;
    bus.in_q     = q;
    bus.clear    = clr;
    @(posedge clk);
    #1;
    $display("t=%0t valid=%0b q=%h clr=%0b locked=%0b err_pulse=%0b err_cnt=%0d stuck=%0b pv=%0b period=%0d",
             $time, v, q, clr, bus.locked, bus.err_pulse, bus.err_cnt, bus.stuck_zero,
             bus.period_valid, bus.period);
    bus.in_valid = 1'b0;
    bus.clear    = 1'b0;
  endtask

  task automatic clean();
    send(1'b1, gen, 1'b0);
    gen = lfsr_step(gen);
  endtask

  task automatic bad(input logic clr);
    send(1'b1, gen ^ flip3, clr);
    gen = lfsr_step(gen);
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    #2;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0; bus.in_q = '0; bus.clear = 1'b0;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (bus.locked !== 1'b0) begin n_bad++; $display("FAIL reset_locked: got %b want 0", bus.locked); end
    n_cmp++; if (bus.err_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_err_cnt: got %0d want 0", bus.err_cnt); end
    n_cmp++; if ({bus.err_pulse, bus.stuck_zero, bus.period_valid} !== 3'b000 || bus.period !== 16'd0)
      begin n_bad++; $display("FAIL reset_flags: got pulse/stuck/pv=%b%b%b period=%0d want 0", bus.err_pulse, bus.stuck_zero, bus.period_valid, bus.period); end
    reset = 1'b1;
  endtask

  task automatic test_clean_lock();
    gen = 8'h01;
    for (int k = 1; k <= 5; k++) begin
      clean();
      n_cmp++;
      if (bus.locked !== (k == 5)) begin n_bad++; $display("FAIL clean_lock_s%0d: got %b want %b", k, bus.locked, (k == 5)); end
    end
    for (int k = 0; k < 4; k++) begin
      clean();
      n_cmp++;
      if (bus.err_cnt !== 16'd0 || bus.err_pulse !== 1'b0 || bus.locked !== 1'b1)
        begin n_bad++; $display("FAIL clean_run: got err_cnt=%0d pulse=%b locked=%b want 0/0/1", bus.err_cnt, bus.err_pulse, bus.locked); end
    end
  endtask

  task automatic test_single_flip();
    bad(1'b0);
    n_cmp++; if (bus.err_pulse !== 1'b1) begin n_bad++; $display("FAIL flip_pulse: got %b want 1", bus.err_pulse); end
    n_cmp++; if (bus.err_cnt !== 16'd1) begin n_bad++; $display("FAIL flip_cnt: got %0d want 1", bus.err_cnt); end
    n_cmp++; if (bus.locked !== 1'b1) begin n_bad++; $display("FAIL flip_locked: got %b want 1", bus.locked); end
    clean();
    n_cmp++; if (bus.err_pulse !== 1'b0 || bus.err_cnt !== 16'd1)
      begin n_bad++; $display("FAIL flip_after: got pulse=%b cnt=%0d want 0/1", bus.err_pulse, bus.err_cnt); end
  endtask

  task automatic test_burst();
    send(1'b0, 8'h5A, 1'b1);
    n_cmp++; if (bus.err_cnt !== 16'd0) begin n_bad++; $display("FAIL burst_clear: got %0d want 0", bus.err_cnt); end
    for (int k = 1; k <= 3; k++) begin
      bad(1'b0);
      n_cmp++;
      if (bus.err_cnt !== 16'(k) || bus.err_pulse !== 1'b1 || bus.locked !== (k != 3))
        begin n_bad++; $display("FAIL burst_s%0d: got cnt=%0d pulse=%b locked=%b want %0d/1/%b", k, bus.err_cnt, bus.err_pulse, bus.locked, k, (k != 3)); end
    end
    for (int k = 1; k <= 5; k++) begin
      clean();
      n_cmp++;
      if (bus.locked !== (k == 5) || bus.err_cnt !== 16'd3)
        begin n_bad++; $display("FAIL relock_s%0d: got locked=%b cnt=%0d want %b/3", k, bus.locked, bus.err_cnt, (k == 5)); end
    end
  endtask

  task automatic test_gaps();
    apply_reset();
    gen = 8'h01;
    for (int k = 1; k <= 5; k++) begin
      clean();
      n_cmp++;
      if (bus.locked !== (k == 5)) begin n_bad++; $display("FAIL gap_lock_s%0d: got %b want %b", k, bus.locked, (k == 5)); end
      send(1'b0, 8'hA5, 1'b0);
      send(1'b0, 8'h3C, 1'b0);
    end
    n_cmp++; if (bus.locked !== 1'b1 || bus.err_pulse !== 1'b0 || bus.err_cnt !== 16'd0)
      begin n_bad++; $display("FAIL gap_idle_hold: got locked=%b pulse=%b cnt=%0d want 1/0/0", bus.locked, bus.err_pulse, bus.err_cnt); end
    clean();
    n_cmp++; if (bus.err_cnt !== 16'd0) begin n_bad++; $display("FAIL gap_resume: got %0d want 0", bus.err_cnt); end
  endtask

  task automatic test_zero_clear();
    apply_reset();
    send(1'b1, 8'h00, 1'b0);
    n_cmp++; if (bus.stuck_zero !== 1'b1 || bus.locked !== 1'b0)
      begin n_bad++; $display("FAIL zero_hunt: got stuck=%b locked=%b want 1/0", bus.stuck_zero, bus.locked); end
    gen = 8'h01;
    for (int k = 1; k <= 5; k++) begin
      clean();
      n_cmp++;
      if (bus.locked !== (k == 5)) begin n_bad++; $display("FAIL zero_relock_s%0d: got %b want %b", k, bus.locked, (k == 5)); end
    end
    n_cmp++; if (bus.stuck_zero !== 1'b1) begin n_bad++; $display("FAIL zero_sticky: got %b want 1", bus.stuck_zero); end
    bad(1'b0); clean(); bad(1'b0); clean();
    n_cmp++; if (bus.err_cnt !== 16'd2) begin n_bad++; $display("FAIL zero_pre_clear: got %0d want 2", bus.err_cnt); end
    bad(1'b1);
    n_cmp++; if (bus.err_cnt !== 16'd1 || bus.err_pulse !== 1'b1)
      begin n_bad++; $display("FAIL clear_with_err: got cnt=%0d pulse=%b want 1/1", bus.err_cnt, bus.err_pulse); end
    n_cmp++; if (bus.stuck_zero !== 1'b0 || bus.locked !== 1'b1)
      begin n_bad++; $display("FAIL clear_stuck: got stuck=%b locked=%b want 0/1", bus.stuck_zero, bus.locked); end
  endtask

  task automatic test_reset_mid();
    clean(); bad(1'b0);
    n_cmp++; if (bus.err_cnt !== 16'd2 || bus.locked !== 1'b1)
      begin n_bad++; $display("FAIL mid_pre: got cnt=%0d locked=%b want 2/1", bus.err_cnt, bus.locked); end
    reset = 1'b0;
    #2;
    n_cmp++; if (bus.locked !== 1'b0 || bus.err_cnt !== 16'd0 || bus.err_pulse !== 1'b0 || bus.stuck_zero !== 1'b0)
      begin n_bad++; $display("FAIL mid_reset: got locked=%b cnt=%0d pulse=%b stuck=%b want 0", bus.locked, bus.err_cnt, bus.err_pulse, bus.stuck_zero); end
    reset = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      clean();
      n_cmp++;
      if (bus.locked !== (k == 5)) begin n_bad++; $display("FAIL mid_relock_s%0d: got %b want %b", k, bus.locked, (k == 5)); end
    end
  endtask

  task automatic test_period();
    int pulses;
    int last;
    apply_reset();
    gen = 8'h01;
    repeat (5) clean();
    n_cmp++; if (bus.locked !== 1'b1) begin n_bad++; $display("FAIL period_lock: got %b want 1", bus.locked); end
    pulses = 0;
    last = 1;
`ifdef LFSR_CHK_PERIOD_EN
    for (int k = 1; k <= 600; k++) begin
      clean();
      if (bus.period_valid === 1'b1) begin
        pulses++;
        n_cmp++;
        if (k != last + 255 || bus.period !== 16'd255)
          begin n_bad++; $display("FAIL period_pulse: got at=%0d period=%0d want at=%0d period=255", k, bus.period, last + 255); end
        last = k;
      end
    end
    n_cmp++; if (pulses != 2) begin n_bad++; $display("FAIL period_count: got %0d want 2", pulses); end
`else
    for (int k = 1; k <= 20; k++) begin
      clean();
      n_cmp++;
      if (bus.period_valid !== 1'b0 || bus.period !== 16'd0)
        begin n_bad++; $display("FAIL period_off: got pv=%b period=%0d want 0/0", bus.period_valid, bus.period); end
    end
`endif
  endtask

  initial begin
    flip3 = '0;
    flip3[3] = 1'b1;
    test_reset();
    test_clean_lock();
    test_single_flip();
    test_burst();
    test_gaps();
    test_zero_clear();
    test_reset_mid();
    test_period();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/lfsr_checker.md
# lfsr_checker

Downstream consumer of the `LFSR` pseudo-random generator. It receives the generator's parallel state `Q` each cycle and regenerates the expected sequence locally using the same feedback polynomial. It locks onto the incoming stream, counts mismatches, and optionally measures the sequence period, so that generator integrity can be checked in system and on the bench.

## Interface
- `N`, 8: state width. Must match the upstream `LFSR` `n`.
- `TAPS`, `8'b00011101`: feedback mask, indexed `[1:N]`. Bit i set means stage i feeds the XOR. The default is taps 4, 5, 6, 8.
- `LOCK_CNT`, 4: consecutive matches required to declare lock (1..15).
- `UNLOCK_CNT`, 3: consecutive mismatches while locked that drop lock (1..15).

Ports:
- `clk` input 1: rising-edge clock.
- `reset` input 1: asynchronous, active-low reset.
- `in_valid` input 1: `in_q` is a valid sample this cycle.
- `in_q` input `[1:N]`: generator state (`LFSR.Q`).
- `clear` input 1: synchronous clear of `err_cnt` and the sticky flags.
- `locked` output 1: checker is in LOCKED.
- `err_pulse` output 1: one-cycle pulse per mismatch counted while locked.
- `err_cnt` output 16: saturating mismatch count.
- `stuck_zero` output 1: sticky; an all-zero sample was received.
- `period` output 16: last measured period, in valid samples.
- `period_valid` output 1: one-cycle pulse when `period` updates.

## Operation
- Next-state function `f(s)`:
  - `f[1]` is the XOR over i of `s[i] & TAPS[i]`.
  - `f[i] = s[i-1]` for i = 2..N.
- Only cycles with `in_valid`=1 are processed. Idle cycles hold all state.
- FSM states are HUNT, CONFIRM and LOCKED. Reset state is HUNT.
- HUNT:
  - Valid non-zero sample: load `pred <= f(in_q)`, `match_cnt <= 0`, go to CONFIRM.
  - All-zero sample: set `stuck_zero`, stay in HUNT.
- CONFIRM:
  - `in_q == pred`: `match_cnt++`, `pred <= f(pred)`. When `match_cnt` reaches `LOCK_CNT`, go to LOCKED.
  - Mismatch: reseed with `pred <= f(in_q)`, `match_cnt <= 0`, stay in CONFIRM.
  - Errors are not counted in CONFIRM.
- LOCKED:
  - `pred <= f(pred)` on every valid sample (flywheel, never reseeded from input).
  - Mismatch: `err_cnt++` (saturates at 16'hFFFF), `err_pulse`=1, `miss_cnt++`. When `miss_cnt` reaches `UNLOCK_CNT`, go to HUNT.
  - Match: `miss_cnt <= 0`.
- `stuck_zero` sets on any valid all-zero sample in any state and clears only on `clear` or reset.
- `clear` and a counted error in the same cycle: `err_cnt` becomes 1 and `err_pulse`=1.
- Reset mid-operation: all state and outputs return to reset values immediately. The next valid sample is treated as in HUNT.

## Timing
- Reset values: `locked`=0, `err_pulse`=0, `err_cnt`=0, `stuck_zero`=0, `period`=0, `period_valid`=0, FSM=HUNT, `pred`=0.
- All outputs are registered.
- `err_pulse` rises the cycle after the offending valid sample and lasts exactly one cycle.
- `locked` rises the cycle after the `LOCK_CNT`-th consecutive matching sample. It falls the cycle after the `UNLOCK_CNT`-th consecutive miss.
- From a clean stream, lock arrives after 1 + `LOCK_CNT` valid samples.
- `in_valid` may toggle arbitrarily. Gaps add latency only.

## Configuration
- `LFSR_CHK_PERIOD_EN` defined: period measurement is built in.
  - On the LOCKED entry cycle, `anchor <= pred` and `pcnt <= 0`.
  - Each valid sample in LOCKED increments `pcnt`.
  - When a valid sample equals `anchor` and `pcnt` ≠ 0: `period <= pcnt`, `period_valid` pulses next cycle, `pcnt` restarts at 1.
  - `pcnt` saturates at 16'hFFFF without reporting.
  - Leaving LOCKED abandons the measurement.
- `LFSR_CHK_PERIOD_EN` undefined: no anchor or counter logic is built. `period`=0 and `period_valid`=0 constantly.

## Test plan
- Clean stream: upstream `LFSR` (N=8, seed 1) with `in_valid`=1 → `locked`=1 after the 5th sample, `err_cnt` stays 0.
- Period (macro on): keep the clean stream for 600 cycles after lock → `period_valid` pulses every 255 cycles with `period`=255.
- Single flip: invert `in_q[3]` on one sample while locked → one `err_pulse`, `err_cnt`=1, `locked` stays 1.
- Burst: corrupt 3 consecutive samples → `err_cnt`=3, `locked`=0 the cycle after the 3rd. A clean stream then relocks after 5 samples.
- Zero and clear:
  - Drive an all-zero sample in HUNT → `stuck_zero`=1, FSM stays HUNT.
  - Pulse `clear` together with an error while locked → `err_cnt`=1, `stuck_zero`=0.
- Reset mid-run: assert `reset` low for 2 ns while locked with `err_cnt`=2 → all outputs 0 immediately. Relock after 5 samples.
